pmp_unit: RTL and testbench



---
 rtl/pmp_unit_pkg.sv | 61 ++++++
 rtl/pmp_unit_if.sv | 31 +++
 rtl/pmp_entry_match.sv | 51 +++++
 rtl/pmp_unit.sv | 153 +++++++++++++++
 tb/tb_pmp_unit.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pmp_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cep_define (package)
// Purpose  : Shared types and constants for the PMP unit: cfg byte layout,
//            address-matching modes, access operations and CSR bases.
// Revision : 1.0 - initial release
// ============================================================================
package cep_define;

  localparam int unsigned NUM_ENTRIES = 16;

  // Address-matching mode held in cfg bits [4:3]
  typedef enum logic [1:0] {
    A_OFF   = 2'd0,
    A_TOR   = 2'd1,
    A_NA4   = 2'd2,
    A_NAPOT = 2'd3
  } pmp_amode_e;

  // One pmpcfg byte: {L, rsv[1:0], A[1:0], X, W, R}
  typedef struct packed {
    logic       l;
    logic [1:0] rsv;
    pmp_amode_e a;
    logic       x;
    logic       w;
    logic       r;
  } pmpcfg_t;

  // Access operation codes; a denied access reports its own code
  localparam logic [1:0] OPER_READ  = 2'd0;
  localparam logic [1:0] OPER_WRITE = 2'd1;
  localparam logic [1:0] OPER_EXEC  = 2'd2;
  localparam logic [1:0] OPER_RSVD  = 2'd3;

  // Privilege level allowed to touch the CSRs and bypass unlocked entries
  localparam logic [1:0] PRIV_CFG = 2'b00;

  // CSR window bases (low 12 bits of the CSR address)
  localparam logic [11:0] CSR_CFG_BASE  = 12'h3A0;
  localparam logic [11:0] CSR_ADDR_BASE = 12'h3B0;

  // Trailing-ones count of a NAPOT address. The 5-bit counter wraps to 0
  // when all 32 bits are ones, which is exactly the required t=0 case.
  function automatic logic [4:0] trailing_ones(input logic [31:0] v);
    logic [4:0] n;
    logic       run;
    n   = 5'd0;
    run = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (run && v[i]) begin
        n = n + 5'd1;
      end else begin
        run = 1'b0;
      end
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pmp_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : pmp_unit_if
// Purpose  : CSR access port plus access-check port of the PMP unit.
//            master = CSR file / LSU side, slave = PMP unit.
// Revision : 1.0 - initial release
// ============================================================================
interface pmp_unit_if;

  logic        wr_en;
  logic [31:0] rw_addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [1:0]  priv_mode;
  logic [31:0] addr;
  logic [1:0]  size;
  logic [1:0]  oper;
  logic [1:0]  permission;

  modport master (
    output wr_en, rw_addr, wdata, priv_mode, addr, size, oper,
    input  rdata, permission
  );

  modport slave (
    input  wr_en, rw_addr, wdata, priv_mode, addr, size, oper,
    output rdata, permission
  );

endinterface
`default_nettype wire

// File: rtl/pmp_entry_match.sv
`default_nettype none
// ============================================================================
// Module   : pmp_entry_match
// Purpose  : Address-range match of one PMP entry against an access end
//            address. Raw pmpaddr values are compared without scaling.
// Revision : 1.0 - initial release
// ============================================================================
module pmp_entry_match
  import cep_define::*;
(
  input  pmpcfg_t     cfg_i,
  input  logic [31:0] addr_k_i,
  input  logic [31:0] addr_prev_i,
  input  logic [31:0] ea_i,
  output logic        match_o
);

  logic [4:0]  napot_t;
  logic [31:0] napot_base;
  logic [35:0] ea_ext;
  logic [35:0] na4_lo;
  logic [35:0] na4_hi;
  logic [35:0] napot_lo;
  logic [35:0] napot_hi;
  logic [5:0]  cfg_unused;

  // Only the A field matters for matching; permissions are applied upstream
  assign cfg_unused = {cfg_i.l, cfg_i.rsv, cfg_i.x, cfg_i.w, cfg_i.r};

  // Upper bounds are formed in 36 bits so a region touching 2^32 cannot wrap
  assign napot_t    = trailing_ones(addr_k_i);
  assign napot_base = addr_k_i & (~32'd0 << napot_t);
  assign ea_ext     = {4'd0, ea_i};
  assign na4_lo     = {4'd0, addr_k_i};
  assign na4_hi     = {4'd0, addr_k_i} + 36'd4;
  assign napot_lo   = {4'd0, napot_base};
  assign napot_hi   = {4'd0, napot_base} + (36'd8 << napot_t);

  // Mode-dependent range test
  always_comb begin
    match_o = 1'b0;
    case (cfg_i.a)
      A_TOR:   match_o = (addr_prev_i <= ea_i) && (ea_i < addr_k_i);
      A_NA4:   match_o = (ea_ext >= na4_lo) && (ea_ext < na4_hi);
      A_NAPOT: match_o = (ea_ext >= napot_lo) && (ea_ext < napot_hi);
      default: match_o = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pmp_unit.sv
`default_nettype none
// ============================================================================
// Module   : pmp_unit
// Purpose  : 16-entry physical memory protection: pmpcfg0..3 / pmpaddr0..15
//            CSRs with locking, and a combinational access permission check.
// Revision : 1.0 - initial release
// ============================================================================
module pmp_unit
  import cep_define::*;
(
  input  logic      clock,
  input  logic      reset,
  pmp_unit_if.slave bus
);

  pmpcfg_t     cfg_q  [NUM_ENTRIES];
  pmpcfg_t     cfg_d  [NUM_ENTRIES];
  logic [31:0] addr_q [NUM_ENTRIES];
  logic [31:0] addr_d [NUM_ENTRIES];

  logic [11:0] csr_sel;
  logic [19:0] rw_addr_unused;
  logic        cfg_hit;
  logic        addr_hit;
  logic [1:0]  cfg_idx;
  logic [3:0]  addr_idx;
  logic        priv_cfg;
  logic        csr_wr;
  logic [15:0] addr_locked;

  logic [31:0] ea;
  logic [15:0] match;
  logic        hit;
  logic [3:0]  hit_idx;
  logic        op_bit;
  logic        grant;

  // Only the low 12 address bits select a CSR
  assign csr_sel        = bus.rw_addr[11:0];
  assign rw_addr_unused = bus.rw_addr[31:12];
  assign cfg_hit        = (csr_sel[11:2] == CSR_CFG_BASE[11:2]);
  assign addr_hit       = (csr_sel[11:4] == CSR_ADDR_BASE[11:4]);
  assign cfg_idx        = csr_sel[1:0];
  assign addr_idx       = csr_sel[3:0];
  assign priv_cfg       = (bus.priv_mode == PRIV_CFG);
  assign csr_wr         = bus.wr_en & priv_cfg;

  // An address is frozen by its own lock, or by a locked TOR entry above it
  // that uses it as the lower bound
  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_lock
    if (i < NUM_ENTRIES - 1) begin : g_chain
      assign addr_locked[i] = cfg_q[i].l |
                              (cfg_q[i+1].l & (cfg_q[i+1].a == A_TOR));
    end else begin : g_last
      assign addr_locked[i] = cfg_q[i].l;
    end
  end

  // Next-state: apply a CSR write to every unlocked target byte/word
  always_comb begin
    cfg_d  = cfg_q;
    addr_d = addr_q;
    if (csr_wr && cfg_hit) begin
      for (int j = 0; j < 4; j++) begin
        if (!cfg_q[{cfg_idx, 2'(j)}].l) begin
          cfg_d[{cfg_idx, 2'(j)}] = pmpcfg_t'(bus.wdata[8*j +: 8]);
        end
      end
    end
    if (csr_wr && addr_hit && !addr_locked[addr_idx]) begin
      addr_d[addr_idx] = bus.wdata;
    end
  end

  // State registers; reset clears everything, including locks
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int k = 0; k < NUM_ENTRIES; k++) begin
        cfg_q[k]  <= '0;
        addr_q[k] <= '0;
      end
    end else begin
      cfg_q  <= cfg_d;
      addr_q <= addr_d;
    end
  end

  // CSR read mux; nothing is visible outside the configuration privilege
  always_comb begin
    bus.rdata = 32'd0;
    if (priv_cfg) begin
      if (cfg_hit) begin
        bus.rdata = {cfg_q[{cfg_idx, 2'd3}], cfg_q[{cfg_idx, 2'd2}],
                     cfg_q[{cfg_idx, 2'd1}], cfg_q[{cfg_idx, 2'd0}]};
      end else if (addr_hit) begin
        bus.rdata = addr_q[addr_idx];
      end
    end
  end

  // Access end address, 32-bit wrap-around
  assign ea = bus.addr + {30'd0, bus.size};

  for (genvar k = 0; k < NUM_ENTRIES; k++) begin : g_entry
    logic [31:0] prev;
    if (k == 0) begin : g_first
      assign prev = 32'd0;
    end else begin : g_rest
      assign prev = addr_q[k-1];
    end
    pmp_entry_match u_match (
      .cfg_i       (cfg_q[k]),
      .addr_k_i    (addr_q[k]),
      .addr_prev_i (prev),
      .ea_i        (ea),
      .match_o     (match[k])
    );
  end

  // Priority encoder: lowest-index matching entry wins
  always_comb begin
    hit     = 1'b0;
    hit_idx = 4'd0;
    for (int k = NUM_ENTRIES - 1; k >= 0; k--) begin
      if (match[k]) begin
        hit     = 1'b1;
        hit_idx = 4'(k);
      end
    end
  end

  // Permission mux: the winning entry's R/W/X bit applies below config
  // privilege or when locked; an unmatched access is config-privilege only
  always_comb begin
    op_bit = 1'b1;
    case (bus.oper)
      OPER_READ:  op_bit = cfg_q[hit_idx].r;
      OPER_WRITE: op_bit = cfg_q[hit_idx].w;
      OPER_EXEC:  op_bit = cfg_q[hit_idx].x;
      default:    op_bit = 1'b1;
    endcase
    if (bus.oper == OPER_RSVD) begin
      grant = 1'b1;
    end else if (hit) begin
      grant = (!priv_cfg || cfg_q[hit_idx].l) ? op_bit : 1'b1;
    end else begin
      grant = priv_cfg;
    end
    bus.permission = grant ? 2'b11 : bus.oper;
  end

endmodule
`default_nettype wire

// File: tb/tb_pmp_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pmp_unit
// Purpose  : Directed self-checking bench for pmp_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pmp_unit;
  import cep_define::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  pmp_unit_if bus_if ();

  pmp_unit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clock = ~clock;

  task automatic csr_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] p);
    @(negedge clock);
    bus_if.wr_en     = 1'b1;
    bus_if.rw_addr   = a;
    bus_if.wdata     = d;
    bus_if.priv_mode = p;
    @(posedge clock);
    #1;
    bus_if.wr_en = 1'b0;
  endtask

  task automatic csr_read(input logic [31:0] a, input logic [1:0] p, output logic [31:0] d);
    @(negedge clock);
    bus_if.rw_addr   = a;
    bus_if.priv_mode = p;
    #2;
    d = bus_if.rdata;
  endtask

  task automatic access(input logic [1:0] p, input logic [31:0] a, input logic [1:0] s, input logic [1:0] o);
    @(negedge clock);
    bus_if.priv_mode = p;
    bus_if.addr      = a;
    bus_if.size      = s;
    bus_if.oper      = o;
    #2;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [31:0] a;
    bus_if.wr_en = 1'b0; bus_if.rw_addr = '0; bus_if.wdata = '0;
    bus_if.priv_mode = 2'b00; bus_if.addr = '0; bus_if.size = '0; bus_if.oper = '0;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a = (i < 4) ? (32'h3A0 + 32'(i)) : (32'h3B0 + 32'(i - 4));
      csr_read(a, 2'b00, rd);
      n_cmp++;
      if (rd !== 32'd0) begin n_err++; $display("FAIL reset_read[%h]: got %h want 00000000", a, rd); end
    end
    access(2'b01, 32'h10, 2'd0, OPER_READ);
    n_cmp++;
    if (bus_if.permission !== 2'b00) begin n_err++; $display("FAIL reset_perm_u: got %b want 00", bus_if.permission); end
    access(2'b00, 32'h10, 2'd0, OPER_READ);
    n_cmp++;
    if (bus_if.permission !== 2'b11) begin n_err++; $display("FAIL reset_perm_m: got %b want 11", bus_if.permission); end
  endtask

  task automatic test_tor();
    logic [31:0] rd;
    csr_write(32'h3B0, 32'h100, 2'b00);
    csr_write(32'h3A0, 32'h09, 2'b00);
    csr_read(32'h3A0, 2'b00, rd);
    n_cmp++;
    if (rd !== 32'h09) begin n_err++; $display("FAIL tor_cfg_rd: got %h want 00000009", rd); end
    csr_read(32'h3B0, 2'b00, rd);
    n_cmp++;
    if (rd !== 32'h100) begin n_err++; $display("FAIL tor_addr_rd: got %h want 00000100", rd); end
    access(2'b01, 32'hFC, 2'd3, OPER_READ);
    n_cmp++;
    if (bus_if.permission !== 2'b11) begin n_err++; $display("FAIL tor_read_in: got %b want 11", bus_if.permission); end
    access(2'b01, 32'hFC, 2'd3, OPER_WRITE);
    n_cmp++;
    if (bus_if.permission !== 2'b01) begin n_err++; $display("FAIL tor_write_in: got %b want 01", bus_if.permission); end
    access(2'b01, 32'h100, 2'd0, OPER_READ);
    n_cmp++;
    if (bus_if.permission !== 2'b00) begin n_err++; $display("FAIL tor_top_edge: got %b want 00", bus_if.permission); end
  endtask

  task automatic test_napot();
    csr_write(32'h3B1, 32'h203, 2'b00);
    csr_write(32'h3A0, 32'h1C09, 2'b00);
    access(2'b01, 32'h21F, 2'd0, OPER_EXEC);
    n_cmp++;
    if (bus_if.permission !== 2'b11) begin n_err++; $display("FAIL napot_last: got %b want 11", bus_if.permission); end
    access(2'b01, 32'h220, 2'd0, OPER_EXEC);
    n_cmp++;
    if (bus_if.permission !== 2'b10) begin n_err++; $display("FAIL napot_past: got %b want 10", bus_if.permission); end
    access(2'b01, 32'h21D, 2'd3, OPER_EXEC);
    n_cmp++;
    if (bus_if.permission !== 2'b10) begin n_err++; $display("FAIL napot_size_end: got %b want 10", bus_if.permission); end
    access(2'b01, 32'h200, 2'd0, OPER_EXEC);
    n_cmp++;
    if (bus_if.permission !== 2'b11) begin n_err++; $display("FAIL napot_base: got %b want 11", bus_if.permission); end
  endtask

  task automatic test_na4();
    csr_write(32'h3B2, 32'h400, 2'b00);
    csr_write(32'h3A0, 32'h111C09, 2'b00);
    access(2'b01, 32'h400, 2'd3, OPER_EXEC);
    n_cmp++;
    if (bus_if.permission !== 2'b10) begin n_err++; $display("FAIL na4_exec_in: got %b want 10", bus_if.permission); end
    access(2'b01, 32'h400, 2'd3, OPER_READ);
    n_cmp++;
    if (bus_if.permission !== 2'b11) begin n_err++; $display("FAIL na4_read_in: got %b want 11", bus_if.permission); end
    access(2'b01, 32'h401, 2'd3, OPER_EXEC);
    n_cmp++;
    if (bus_if.permission !== 2'b10) begin n_err++; $display("FAIL na4_exec_out: got %b want 10", bus_if.permission); end
    access(2'b01, 32'h401, 2'd3, OPER_READ);
    n_cmp++;
    if (bus_if.permission !== 2'b00) begin n_err++; $display("FAIL na4_read_out: got %b want 00", bus_if.permission); end
    access(2'b01, 32'h3FF, 2'd0, OPER_READ);
    n_cmp++;
    if (bus_if.permission !== 2'b00) begin n_err++; $display("FAIL na4_below: got %b want 00", bus_if.permission); end
  endtask

  task automatic test_priority();
    // entry1 becomes NAPOT [0,0x80) with W only, nested inside entry0 (R only)
    csr_write(32'h3B1, 32'h0F, 2'b00);
    csr_write(32'h3A0, 32'h111A09, 2'b00);
    access(2'b01, 32'h10, 2'd0, OPER_READ);
    n_cmp++;
    if (bus_if.permission !== 2'b11) begin n_err++; $display("FAIL prio_read: got %b want 11", bus_if.permission); end
    access(2'b01, 32'h10, 2'd0, OPER_WRITE);
    n_cmp++;
    if (bus_if.permission !== 2'b01) begin n_err++; $display("FAIL prio_write: got %b want 01", bus_if.permission); end
    access(2'b01, 32'h10, 2'd0, OPER_RSVD);
    n_cmp++;
    if (bus_if.permission !== 2'b11) begin n_err++; $display("FAIL oper_rsvd: got %b want 11", bus_if.permission); end
    access(2'b01, 32'h1000, 2'd0, OPER_RSVD);
    n_cmp++;
    if (bus_if.permission !== 2'b11) begin n_err++; $display("FAIL oper_rsvd_nomatch: got %b want 11", bus_if.permission); end
  endtask

  task automatic test_lock();
    logic [31:0] rd;
    // set L on entry0; the check in the write cycle still sees it unlocked
    @(negedge clock);
    bus_if.wr_en = 1'b1; bus_if.rw_addr = 32'h3A0; bus_if.wdata = 32'h111A89;
    bus_if.priv_mode = 2'b00; bus_if.addr = 32'h10; bus_if.size = 2'd0; bus_if.oper = OPER_WRITE;
    #1;
    n_cmp++;
    if (bus_if.permission !== 2'b11) begin n_err++; $display("FAIL same_cycle_pre: got %b want 11", bus_if.permission); end
    @(posedge clock);
    #1 bus_if.wr_en = 1'b0;
    #1;
    n_cmp++;
    if (bus_if.permission !== 2'b01) begin n_err++; $display("FAIL locked_m_write: got %b want 01", bus_if.permission); end
    access(2'b00, 32'h10, 2'd0, OPER_READ);
    n_cmp++;
    if (bus_if.permission !== 2'b11) begin n_err++; $display("FAIL locked_m_read: got %b want 11", bus_if.permission); end
    csr_write(32'h3B0, 32'h500, 2'b00);
    csr_write(32'h3A0, 32'h880000, 2'b00);
    csr_read(32'h3B0, 2'b00, rd);
    n_cmp++;
    if (rd !== 32'h100) begin n_err++; $display("FAIL lock_addr0: got %h want 00000100", rd); end
    csr_read(32'h3A0, 2'b00, rd);
    n_cmp++;
    if (rd !== 32'h880089) begin n_err++; $display("FAIL lock_cfg0: got %h want 00880089", rd); end
    csr_write(32'h3B1, 32'h777, 2'b00);
    csr_read(32'h3B1, 2'b00, rd);
    n_cmp++;
    if (rd !== 32'h0F) begin n_err++; $display("FAIL tor_lock_prev: got %h want 0000000f", rd); end
    csr_write(32'h3B2, 32'h999, 2'b00);
    csr_read(32'h3B2, 2'b00, rd);
    n_cmp++;
    if (rd !== 32'h400) begin n_err++; $display("FAIL lock_addr2: got %h want 00000400", rd); end
    csr_write(32'h3B3, 32'h1234, 2'b01);
    csr_read(32'h3B3, 2'b00, rd);
    n_cmp++;
    if (rd !== 32'h0) begin n_err++; $display("FAIL user_write: got %h want 00000000", rd); end
    csr_write(32'h3B3, 32'hABC, 2'b00);
    csr_read(32'h3B3, 2'b00, rd);
    n_cmp++;
    if (rd !== 32'hABC) begin n_err++; $display("FAIL addr3_write: got %h want 00000abc", rd); end
    csr_read(32'h3A0, 2'b01, rd);
    n_cmp++;
    if (rd !== 32'h0) begin n_err++; $display("FAIL user_read: got %h want 00000000", rd); end
    csr_write(32'h3A4, 32'hFFFFFFFF, 2'b00);
    csr_read(32'h3A4, 2'b00, rd);
    n_cmp++;
    if (rd !== 32'h0) begin n_err++; $display("FAIL unmapped_rd: got %h want 00000000", rd); end
    csr_read(32'h3A1, 2'b00, rd);
    n_cmp++;
    if (rd !== 32'h0) begin n_err++; $display("FAIL unmapped_alias: got %h want 00000000", rd); end
  endtask

  task automatic test_reset_clears();
    logic [31:0] rd;
    // reset together with a write: reset must win
    @(negedge clock);
    reset = 1'b0;
    bus_if.wr_en = 1'b1; bus_if.rw_addr = 32'h3B5; bus_if.wdata = 32'h55; bus_if.priv_mode = 2'b00;
    @(posedge clock);
    #1;
    bus_if.wr_en = 1'b0;
    reset = 1'b1;
    csr_read(32'h3B5, 2'b00, rd);
    n_cmp++;
    if (rd !== 32'h0) begin n_err++; $display("FAIL rst_over_write: got %h want 00000000", rd); end
    csr_read(32'h3A0, 2'b00, rd);
    n_cmp++;
    if (rd !== 32'h0) begin n_err++; $display("FAIL rst_cfg0: got %h want 00000000", rd); end
    access(2'b01, 32'h10, 2'd0, OPER_READ);
    n_cmp++;
    if (bus_if.permission !== 2'b00) begin n_err++; $display("FAIL rst_perm_u: got %b want 00", bus_if.permission); end
    access(2'b00, 32'h10, 2'd0, OPER_WRITE);
    n_cmp++;
    if (bus_if.permission !== 2'b11) begin n_err++; $display("FAIL rst_perm_m: got %b want 11", bus_if.permission); end
    csr_write(32'h3B0, 32'h500, 2'b00);
    csr_read(32'h3B0, 2'b00, rd);
    n_cmp++;
    if (rd !== 32'h500) begin n_err++; $display("FAIL rst_unlock: got %h want 00000500", rd); end
    // entries 12..15; entry15 NAPOT at pmpaddr=0 covers [0,8) with R/W
    csr_write(32'h3A3, 32'h1B6A0907, 2'b00);
    csr_read(32'hFFFFF3A3, 2'b00, rd);
    n_cmp++;
    if (rd !== 32'h1B6A0907) begin n_err++; $display("FAIL cfg3_rd: got %h want 1b6a0907", rd); end
    access(2'b01, 32'h4, 2'd0, OPER_READ);
    n_cmp++;
    if (bus_if.permission !== 2'b11) begin n_err++; $display("FAIL e15_read: got %b want 11", bus_if.permission); end
    access(2'b01, 32'h4, 2'd0, OPER_EXEC);
    n_cmp++;
    if (bus_if.permission !== 2'b10) begin n_err++; $display("FAIL e15_exec: got %b want 10", bus_if.permission); end
    access(2'b01, 32'h5, 2'd3, OPER_READ);
    n_cmp++;
    if (bus_if.permission !== 2'b00) begin n_err++; $display("FAIL e15_past: got %b want 00", bus_if.permission); end
  endtask

  initial begin
    test_reset();
    test_tor();
    test_napot();
    test_na4();
    test_priority();
    test_lock();
    test_reset_clears();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
